// File: rtl/serial_mag_comp.sv
// Bit-serial, MSB-first magnitude comparator with a start/done handshake.
// Scans one bit pair per cycle and stops at the first differing bit (unsigned or two's complement).
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       signed_mode,
    output logic                       busy,
    output logic                       done,
    output logic                       agb,
    output logic                       alb,
    output logic                       aeb,
    output logic [$clog2(WIDTH+1)-1:0] nbits
);

    localparam int IW = $clog2(WIDTH);
    localparam int NW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            signed_q;
    logic [IW-1:0]   idx_q;
    logic            busy_q;
    logic            done_q;
    logic            agb_q;
    logic            alb_q;
    logic            aeb_q;
    logic [NW-1:0]   nbits_q;

    logic            msb_d;
    logic            differ_d;
    logic            a_wins_d;
    logic [NW-1:0]   nbits_d;

    // In signed mode a set sign bit means "more negative", so the MSB winner is inverted.
    always_comb begin
        msb_d    = (idx_q == IW'(WIDTH-1));
        differ_d = a_q[idx_q] ^ b_q[idx_q];
        a_wins_d = a_q[idx_q] ^ (signed_q & msb_d);
        nbits_d  = NW'(WIDTH) - NW'(idx_q);
    end

    // NOTE: every register in this block uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            agb_q    <= 1'b0;
            alb_q    <= 1'b0;
            aeb_q    <= 1'b0;
            nbits_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= signed_mode;
                        idx_q    <= IW'(WIDTH-1);
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (differ_d) begin
                        agb_q   <= a_wins_d;
                        alb_q   <= ~a_wins_d;
                        aeb_q   <= 1'b0;
                        nbits_q <= nbits_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (idx_q == '0) begin
                        agb_q   <= 1'b0;
                        alb_q   <= 1'b0;
                        aeb_q   <= 1'b1;
                        nbits_q <= NW'(WIDTH);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign agb   = agb_q;
    assign alb   = alb_q;
    assign aeb   = aeb_q;
    assign nbits = nbits_q;

endmodule
